pgm_ddr_loader: RTL

PGM_DDR_LOADER -- requirements
Module: pgm_ddr_loader

---
 rtl/pgm_ddr_loader_if.sv | 26 ++
 rtl/pgm_ddr_loader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pgm_ddr_loader_if.sv
// rtl/pgm_ddr_loader_if.sv - HPS download and DDRAM write bundle for the loader
interface pgm_ddr_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        ddram_busy;
    logic        ddram_we;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic        load_done;
    logic        overrun;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, ddram_busy,
        input  ioctl_wait, ddram_we, ddram_addr, ddram_din, ddram_be, load_done, overrun
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, ddram_busy,
        output ioctl_wait, ddram_we, ddram_addr, ddram_din, ddram_be, load_done, overrun
    );
endinterface

// File: rtl/pgm_ddr_loader.sv
// rtl/pgm_ddr_loader.sv - packs 16-bit HPS download words into 64-bit DDRAM writes
module pgm_ddr_loader #(
    parameter logic [28:0] BASE_ADDR = 29'h0300_0000
) (
    input  logic            clk_sys,
    input  logic            reset,
    pgm_ddr_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, FINISH} state_t;

    state_t      state;
    logic [63:0] buf_data;
    logic [7:0]  buf_be;
    logic [26:0] buf_key;
    logic        pend_valid;
    logic [1:0]  pend_lane;
    logic [15:0] pend_data;
    logic [26:0] pend_key;
    logic        dl_q;
    logic        fin_pend;      // buffer was flushed because the download ended

    logic [1:0]  wr_lane;
    logic [26:0] wr_key;
    logic        wr_ok;
    logic [63:0] wr_data;
    logic [63:0] wr_mask;
    logic [7:0]  wr_be;
    logic [63:0] merged_data;
    logic [7:0]  merged_be;
    logic [63:0] pend_word;
    logic [7:0]  pend_be;
    logic        go_flush;
    logic        go_jump;
    logic        go_full;
    logic        unused_bits;

    assign wr_lane     = bus.ioctl_addr[2:1];
    assign wr_key      = {bus.ioctl_index[2:0], bus.ioctl_addr[26:3]};
    assign wr_ok       = bus.ioctl_wr & bus.ioctl_download;
    assign wr_data     = {48'd0, bus.ioctl_dout} << {wr_lane, 4'd0};
    assign wr_mask     = {48'd0, 16'hFFFF} << {wr_lane, 4'd0};
    assign wr_be       = 8'b0000_0011 << {wr_lane, 1'b0};
    assign merged_data = (buf_data & ~wr_mask) | wr_data;
    assign merged_be   = buf_be | wr_be;
    assign pend_word   = {48'd0, pend_data} << {pend_lane, 4'd0};
    assign pend_be     = 8'b0000_0011 << {pend_lane, 1'b0};

    // Reasons to leave COLLECT: download over, a new 64-bit group, or the last lane filled
    assign go_flush    = ~bus.ioctl_download | fin_pend;
    assign go_jump     = ~go_flush & wr_ok & (wr_key != buf_key);
    assign go_full     = ~go_flush & wr_ok & (wr_key == buf_key) & (wr_lane == 2'd3);
    assign unused_bits = &{1'b0, bus.ioctl_addr[0], bus.ioctl_index[7:3]};

    // Loader FSM with registered DDRAM, stall and status outputs
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            buf_data       <= '0;
            buf_be         <= '0;
            buf_key        <= '0;
            pend_valid     <= 1'b0;
            pend_lane      <= '0;
            pend_data      <= '0;
            pend_key       <= '0;
            dl_q           <= 1'b0;
            fin_pend       <= 1'b0;
            bus.ddram_we   <= 1'b0;
            bus.ddram_addr <= '0;
            bus.ddram_din  <= '0;
            bus.ddram_be   <= '0;
            bus.ioctl_wait <= 1'b0;
            bus.load_done  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            dl_q          <= bus.ioctl_download;
            bus.load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        buf_data <= wr_data;
                        buf_be   <= wr_be;
                        buf_key  <= wr_key;
                        state    <= COLLECT;
                    end else if (dl_q && !bus.ioctl_download) begin
                        bus.load_done <= 1'b1;
                        state         <= FINISH;
                    end
                end
                COLLECT: begin
                    if (go_flush || go_jump || go_full) begin
                        bus.ddram_we   <= 1'b1;
                        bus.ioctl_wait <= 1'b1;
                        bus.ddram_addr <= BASE_ADDR + {2'b00, buf_key};
                        bus.ddram_din  <= go_full ? merged_data : buf_data;
                        bus.ddram_be   <= go_full ? merged_be : buf_be;
                        state          <= ISSUE;
                    end
                    if (go_flush) begin
                        fin_pend <= 1'b1;
                    end
                    if (wr_ok && (go_flush || go_jump)) begin
                        pend_valid <= 1'b1;
                        pend_lane  <= wr_lane;
                        pend_data  <= bus.ioctl_dout;
                        pend_key   <= wr_key;
                    end else if (wr_ok) begin
                        buf_data <= merged_data;
                        buf_be   <= merged_be;
                    end
                end
                ISSUE: begin
                    // hps_io should be stalled here; anything that still arrives is lost
                    if (wr_ok) begin
                        bus.overrun <= 1'b1;
                    end
                    if (!bus.ddram_busy) begin
                        bus.ddram_we   <= 1'b0;
                        bus.ioctl_wait <= 1'b0;
                        buf_data       <= '0;
                        buf_be         <= '0;
                        if (pend_valid && !fin_pend) begin
                            buf_data   <= pend_word;
                            buf_be     <= pend_be;
                            buf_key    <= pend_key;
                            pend_valid <= 1'b0;
                            state      <= COLLECT;
                        end else if (fin_pend || !bus.ioctl_download) begin
                            fin_pend      <= 1'b0;
                            bus.load_done <= 1'b1;
                            state         <= FINISH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FINISH: begin
                    // A word captured from a freshly restarted download resumes collection
                    if (pend_valid) begin
                        buf_data   <= pend_word;
                        buf_be     <= pend_be;
                        buf_key    <= pend_key;
                        pend_valid <= 1'b0;
                        state      <= COLLECT;
                    end else if (wr_ok) begin
                        buf_data <= wr_data;
                        buf_be   <= wr_be;
                        buf_key  <= wr_key;
                        state    <= COLLECT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
